// File: rtl/frame110_pkg.sv
// Shared definitions for the "110" sync-line transmitter: state encoding,
// header pattern and a helper that picks header bits in transmit order.
package frame110_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HDR  = 2'b01,
        DATA = 2'b10,
        GAP  = 2'b11
    } state_t;

    localparam logic [2:0] SYNC_HDR = 3'b110;
    localparam int         HDR_LEN  = 3;

    // Header bit idx in line order: idx 0 is the first bit on the wire.
    function automatic logic hdr_bit(input logic [1:0] idx);
        logic [2:0] h;
        h = SYNC_HDR << idx;
        return h[2];
    endfunction

endpackage

// File: rtl/frame_tx110_piso_shift.sv
// Parallel-in serial-out shift register: loads a word, shifts left,
// and exposes the current MSB as the next bit to transmit.
module piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] sreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= sreg << 1;
        end
    end

    assign msb = sreg[DATA_W-1];

endmodule

// File: rtl/frame_tx110.sv
// Serial frame transmitter: header 1,1,0, payload MSB first, then a run of
// idle zeros, all on one registered line bit.
module frame_tx110
    import frame110_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int IDLE_BITS = 2,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              a,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frame_cnt
);

    // One counter serves header, payload and gap phases, so it is sized
    // for the longest of them.
    localparam int CW_D = $clog2(DATA_W + 1);
    localparam int CW_I = $clog2(IDLE_BITS + 1);
    localparam int CW_M = (CW_D > CW_I) ? CW_D : CW_I;
    localparam int BW   = (CW_M > 2) ? CW_M : 2;

    localparam logic [BW-1:0] LAST_HDR = BW'(HDR_LEN - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_GAP = BW'(IDLE_BITS - 1);

    state_t          state;
    logic [BW-1:0]   bit_idx;
    logic            load;
    logic            shift;
    logic            msb;

    assign load  = (state == IDLE) && start;
    assign shift = (state == DATA) || ((state == HDR) && (bit_idx == LAST_HDR));
    assign busy  = ~ready;

    piso_shift #(
        .DATA_W(DATA_W)
    ) u_shift (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .shift(shift),
        .din  (data),
        .msb  (msb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_idx   <= '0;
            a         <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= HDR;
                        bit_idx <= '0;
                        a       <= hdr_bit(2'd0);
                        ready   <= 1'b0;
                    end
                end
                HDR: begin
                    if (bit_idx == LAST_HDR) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        a       <= msb;
                    end else begin
                        bit_idx <= bit_idx + BW'(1);
                        a       <= hdr_bit(bit_idx[1:0] + 2'd1);
                    end
                end
                DATA: begin
                    if (bit_idx == LAST_BIT) begin
                        state     <= GAP;
                        bit_idx   <= '0;
                        a         <= 1'b0;
                        done      <= 1'b1;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end else begin
                        bit_idx <= bit_idx + BW'(1);
                        a       <= msb;
                    end
                end
                GAP: begin
                    if (bit_idx == LAST_GAP) begin
                        state   <= IDLE;
                        bit_idx <= '0;
                        ready   <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_tx110.sv
// Bench for frame_tx110: per-cycle scoreboard of the line outputs plus
// directed checks of timing, loopback hits, back-to-back, reset and wrap.
module tb_frame_tx110;

    localparam int DW = 8;
    localparam int IB = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data;
    logic       ready, a, busy, done;
    logic [7:0] frame_cnt;

    logic       start2;
    logic [7:0] data2;
    logic       ready2, a2, busy2, done2;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    frame_tx110 #(.DATA_W(DW), .IDLE_BITS(IB), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .data(data),
        .ready(ready), .a(a), .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    frame_tx110 #(.DATA_W(DW), .IDLE_BITS(IB), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .data(data2),
        .ready(ready2), .a(a2), .busy(busy2), .done(done2), .frame_cnt(cnt2)
    );

    typedef struct packed {
        logic       ready;
        logic       done;
        logic       a;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] want;
    } chk_t;

    exp_t       sq[$];
    chk_t       cq[$];
    int         total = 0;
    int         bad   = 0;
    int         hits  = 0;
    logic [1:0] hist  = 2'b00;
    logic [7:0] exp_cnt = 8'd0;
    bit         mon_en  = 1'b0;

    exp_t        m_e;
    logic [11:0] m_got, m_want;
    chk_t        m_c;

    // Monitor: one scoreboard entry per cycle while a frame is expected,
    // idle values otherwise; also drains directed checks from stimulus.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if ({hist, a} == 3'b110) hits++;
            hist = {hist[0], a};
            if (sq.size() > 0) begin
                m_e = sq.pop_front();
            end else begin
                m_e.ready = 1'b1;
                m_e.done  = 1'b0;
                m_e.a     = 1'b0;
                m_e.cnt   = exp_cnt;
            end
            m_want = {m_e.ready, ~m_e.ready, m_e.done, m_e.a, m_e.cnt};
            m_got  = {ready, busy, done, a, frame_cnt};
            total++;
            if (m_got !== m_want) begin
                bad++;
                $display("FAIL cycle t=%0t ready,busy,done,a,cnt got=%b want=%b", $time, m_got, m_want);
            end
        end
        while (cq.size() > 0) begin
            m_c = cq.pop_front();
            total++;
            if (m_c.got !== m_c.want) begin
                bad++;
                $display("FAIL %s got=%0h want=%0h", m_c.name, m_c.got, m_c.want);
            end
        end
    end

    task automatic post(input string n, input logic [31:0] g, input logic [31:0] w);
        chk_t c;
        c.name = n;
        c.got  = g;
        c.want = w;
        cq.push_back(c);
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_t e;
        for (int i = 1; i <= 3 + DW + IB; i++) begin
            e.ready = 1'b0;
            e.done  = (i == 4 + DW);
            if (i <= 2)           e.a = 1'b1;
            else if (i == 3)      e.a = 1'b0;
            else if (i <= 3 + DW) e.a = d[DW + 3 - i];
            else                  e.a = 1'b0;
            e.cnt = (i >= 4 + DW) ? exp_cnt + 8'd1 : exp_cnt;
            sq.push_back(e);
        end
        exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        post("ready_wait", {31'd0, ready}, 32'd1);
        data  = d;
        start = 1'b1;
        @(posedge clk);
        push_frame(d);
        #1;
        start = 1'b0;
        data  = 8'h5A;
    endtask

    logic [12:0] rec, drec;
    logic [7:0]  words [5] = '{8'h11, 8'h22, 8'h3C, 8'hC3, 8'h0F};
    logic [1:0]  wexp  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int          base, n;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        data   = 8'h00;
        start2 = 1'b0;
        data2  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        post("reset_out", {28'd0, a, ready, busy, done}, 32'b0100);
        post("reset_cnt", {24'd0, frame_cnt}, 32'd0);
        post("reset_cnt2", {30'd0, cnt2}, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = 8'd0;
        mon_en  = 1'b1;

        // Single frame A5: exact line sequence, done position, ready return
        send(8'hA5);
        rec  = '0;
        drec = '0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rec  = {rec[11:0], a};
            drec = {drec[11:0], done};
        end
        post("a5_seq", {19'd0, rec}, {19'd0, 13'b1101010010100});
        post("a5_done", {19'd0, drec}, {19'd0, 13'b0000000000010});
        @(negedge clk);
        post("a5_ready_back", {31'd0, ready}, 32'd1);
        post("a5_cnt", {24'd0, frame_cnt}, 32'd1);

        // Loopback detector hits
        base = hits;
        send(8'h55);
        repeat (14) @(negedge clk);
        post("det_55", hits - base, 32'd1);
        base = hits;
        send(8'hFF);
        repeat (14) @(negedge clk);
        post("det_ff", hits - base, 32'd2);
        post("cnt_after_ff", {24'd0, frame_cnt}, 32'd3);

        // Back-to-back with start held and data changing mid-frame
        @(posedge clk);
        #1;
        data  = words[0];
        start = 1'b1;
        @(posedge clk);
        push_frame(words[0]);
        for (int k = 1; k < 5; k++) begin
            #1;
            data = words[k];
            repeat (14) @(posedge clk);
            push_frame(words[k]);
        end
        #1;
        start = 1'b0;
        repeat (16) @(negedge clk);
        post("b2b_cnt", {24'd0, frame_cnt}, 32'd8);

        // Start while busy is dropped
        send(8'h81);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        post("busy_start_cnt", {24'd0, frame_cnt}, 32'd9);

        // Reset together with start: nothing captured
        @(posedge clk);
        #1;
        reset   = 1'b1;
        start   = 1'b1;
        data    = 8'hF0;
        sq.delete();
        exp_cnt = 8'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        post("rst_start_cnt", {24'd0, frame_cnt}, 32'd0);
        post("rst_start_ready", {31'd0, ready}, 32'd1);

        // Reset during payload bit 3
        send(8'hA5);
        repeat (7) @(posedge clk);
        #1;
        reset   = 1'b1;
        sq.delete();
        exp_cnt = 8'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        post("midrst_a", {31'd0, a}, 32'd0);
        post("midrst_ready", {31'd0, ready}, 32'd1);
        repeat (16) @(negedge clk);
        post("midrst_cnt", {24'd0, frame_cnt}, 32'd0);
        send(8'h3C);
        repeat (15) @(negedge clk);
        post("after_rst_cnt", {24'd0, frame_cnt}, 32'd1);

        // Counter wrap on the 2-bit instance
        @(posedge clk);
        #1;
        reset   = 1'b1;
        sq.delete();
        exp_cnt = 8'd0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        start2 = 1'b1;
        data2  = 8'h6B;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done2 && n < 40);
            if (done2) post($sformatf("wrap_%0d", k), {30'd0, cnt2}, {30'd0, wexp[k]});
            else       post($sformatf("wrap_timeout_%0d", k), 32'd0, 32'd1);
        end
        start2 = 1'b0;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
